// File: rtl/parser.sv
// parser: 32-bit valid/ready byte-stream packet parser.
// Gathers the little-endian header (length, stream ID, sequence number) and up
// to 31 payload bytes, then presents the packet as one 296-bit output word.
// Optional build macro PARSER_SEQ_CHECK_EN adds a per-stream sequence table
// that drives packetLost; without it packetLost is tied low.
module parser #(
    parameter int NUM_STREAMS = 16
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic [31:0]   dataIn,
    input  logic          dataIn_val,
    output logic          dataIn_ready,
    input  logic          dataIN_last,
    output logic [0:295]  dataOut,
    output logic          dataOut_val,
    input  logic          dataOut_ready,
    output logic          packetLost
);

    localparam logic [1:0] S_HDR0 = 2'd0;
    localparam logic [1:0] S_HDR1 = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    // Table is indexed by low stream-ID bits, so the size must be a power of 2.
    if (NUM_STREAMS < 2 || NUM_STREAMS > 65536 ||
        (NUM_STREAMS & (NUM_STREAMS - 1)) != 0) begin : g_bad_cfg
        $error("parser: NUM_STREAMS must be a power of 2 in 2..65536");
    end

    logic [1:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       sid_q, sid_d;
    logic [31:0]       seq_q, seq_d;
    logic [30:0][7:0]  pay_q, pay_d;   // pay_q[k] = payload byte k
    logic [3:0]        pw_q, pw_d;     // payload word index, saturates at 8
    logic [0:295]      dout_q, dout_d;

    logic beat, last_beat, out_hs;

    assign dataIn_ready = !reset_b && (state_q != S_OUT);
    assign beat         = dataIn_val && dataIn_ready;
    assign last_beat    = beat && dataIN_last;
    assign out_hs       = (state_q == S_OUT) && dataOut_ready;
    assign dataOut_val  = (state_q == S_OUT);
    assign dataOut      = dout_q;

    // Next-state: FSM, header/payload capture and the output word assembly.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sid_d   = sid_q;
        seq_d   = seq_q;
        pay_d   = pay_q;
        pw_d    = pw_q;
        dout_d  = dout_q;

        if (beat) begin
            case (state_q)
                S_HDR0: begin
                    // New packet: anything not received later must read as zero.
                    len_d   = {dataIn[23:16], dataIn[31:24]};
                    sid_d   = {dataIn[7:0],   dataIn[15:8]};
                    seq_d   = '0;
                    pay_d   = '0;
                    pw_d    = '0;
                    state_d = S_HDR1;
                end
                S_HDR1: begin
                    seq_d   = {dataIn[7:0], dataIn[15:8], dataIn[23:16], dataIn[31:24]};
                    state_d = S_PAY;
                end
                default: begin
                    // Payload beyond byte 30 is accepted but dropped.
                    if (!pw_q[3]) begin
                        for (int k = 0; k < 31; k++) begin
                            if ((k / 4) == int'(pw_q))
                                pay_d[k] = dataIn[31 - 8 * (k % 4) -: 8];
                        end
                        pw_d = pw_q + 4'd1;
                    end
                end
            endcase
            if (dataIN_last) begin
                state_d        = S_OUT;
                dout_d[0:15]   = sid_d;
                dout_d[16:47]  = seq_d;
                // Bytes at or past length-8 are masked; compare as k+8 < len
                // so short lengths never underflow.
                for (int k = 0; k < 31; k++) begin
                    if ((17'(k) + 17'd8) < {1'b0, len_d})
                        dout_d[48 + 8 * k +: 8] = pay_d[k];
                    else
                        dout_d[48 + 8 * k +: 8] = 8'h00;
                end
            end
        end else if (out_hs) begin
            state_d = S_HDR0;
        end
    end

    // Parser state registers; dataOut holds its value after the handshake.
    always_ff @(posedge clk) begin
        if (reset_b) begin
            state_q <= S_HDR0;
            len_q   <= '0;
            sid_q   <= '0;
            seq_q   <= '0;
            pay_q   <= '0;
            pw_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sid_q   <= sid_d;
            seq_q   <= seq_d;
            pay_q   <= pay_d;
            pw_q    <= pw_d;
            dout_q  <= dout_d;
        end
    end

`ifdef PARSER_SEQ_CHECK_EN
    localparam int IDXW = $clog2(NUM_STREAMS);

    logic [NUM_STREAMS-1:0] tvld_q;
    logic [15:0]            ttag_q [NUM_STREAMS];
    logic [31:0]            tseq_q [NUM_STREAMS];
    logic [IDXW-1:0]        idx;
    logic                   gap;
    logic                   lost_q;

    // Lookup uses the just-captured ID/seq so the verdict is ready with dataOut_val.
    assign idx = sid_d[IDXW-1:0];
    assign gap = tvld_q[idx] && (ttag_q[idx] == sid_d) &&
                 (seq_d != (tseq_q[idx] + 32'd1));
    assign packetLost = lost_q;

    // Sequence table update and packetLost flag, both on entry to OUT.
    always_ff @(posedge clk) begin
        if (reset_b) begin
            tvld_q <= '0;
            lost_q <= 1'b0;
        end else if (last_beat) begin
            lost_q         <= gap;
            tvld_q[idx]    <= 1'b1;
            ttag_q[idx]    <= sid_d;
            tseq_q[idx]    <= seq_d;
        end else if (out_hs) begin
            lost_q <= 1'b0;
        end
    end
`else
    assign packetLost = 1'b0;
`endif

endmodule

// File: tb/tb_parser.sv
// tb_parser: scoreboard bench for parser. Expected packets are pushed when a
// packet is driven and popped when the DUT presents its output.
module tb_parser;
    localparam int NS = 16;

    logic         clk = 1'b0;
    logic         reset_b = 1'b1;
    logic [31:0]  dataIn = '0;
    logic         dataIn_val = 1'b0;
    logic         dataIN_last = 1'b0;
    logic         dataOut_ready = 1'b0;
    logic         dataIn_ready;
    logic [0:295] dataOut;
    logic         dataOut_val;
    logic         packetLost;

    typedef struct packed {
        logic [0:295] d;
        logic         lost;
    } exp_t;
    typedef logic [31:0] wq_t[$];

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        mv   [NS];
    logic [15:0] mtag [NS];
    logic [31:0] mseq [NS];

    parser #(.NUM_STREAMS(NS)) dut (
        .clk(clk), .reset_b(reset_b),
        .dataIn(dataIn), .dataIn_val(dataIn_val), .dataIn_ready(dataIn_ready),
        .dataIN_last(dataIN_last),
        .dataOut(dataOut), .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready),
        .packetLost(packetLost)
    );

    always #5 clk = ~clk;

    function automatic wq_t mk(input int len, input int sid, input logic [31:0] seq, input int npay);
        wq_t w;
        logic [15:0] l;
        logic [15:0] s;
        l = len[15:0];
        s = sid[15:0];
        w.push_back({l[7:0], l[15:8], s[7:0], s[15:8]});
        w.push_back({seq[7:0], seq[15:8], seq[23:16], seq[31:24]});
        for (int i = 0; i < npay; i++) w.push_back($urandom);
        return w;
    endfunction

    // Reference model: byte-level parse plus the per-stream sequence table.
    function automatic exp_t model(input wq_t w);
        logic [7:0]  b[$];
        int          n;
        logic [15:0] len;
        logic [15:0] sid;
        logic [31:0] seq;
        exp_t        e;
        int          ix;
        foreach (w[i]) begin
            b.push_back(w[i][31:24]); b.push_back(w[i][23:16]);
            b.push_back(w[i][15:8]);  b.push_back(w[i][7:0]);
        end
        n   = b.size();
        len = {b[1], b[0]};
        sid = {b[3], b[2]};
        seq = (n >= 8) ? {b[7], b[6], b[5], b[4]} : 32'd0;
        e = '0;
        e.d[0:15]  = sid;
        e.d[16:47] = seq;
        for (int k = 0; k < 31; k++)
            if (8 + k < n && 8 + k < int'(len)) e.d[48 + 8 * k +: 8] = b[8 + k];
        ix = int'(sid) % NS;
`ifdef PARSER_SEQ_CHECK_EN
        e.lost = mv[ix] && (mtag[ix] == sid) && (seq != mseq[ix] + 32'd1);
`else
        e.lost = 1'b0;
`endif
        mv[ix] = 1'b1; mtag[ix] = sid; mseq[ix] = seq;
        return e;
    endfunction

    task automatic do_reset();
        dataIn_val = 1'b0; dataIN_last = 1'b0; dataOut_ready = 1'b0;
        reset_b = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (dataIn_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", dataIn_ready); end
        n_cmp++; if (dataOut_val !== 1'b0) begin n_err++; $display("FAIL rst_out_val: got %b want 0", dataOut_val); end
        n_cmp++; if (packetLost !== 1'b0) begin n_err++; $display("FAIL rst_lost: got %b want 0", packetLost); end
        n_cmp++; if (dataOut !== 296'd0) begin n_err++; $display("FAIL rst_dout: got %h want 0", dataOut); end
        @(posedge clk); #1;
        reset_b = 1'b0;
        #1;
        n_cmp++; if (dataIn_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", dataIn_ready); end
        for (int i = 0; i < NS; i++) mv[i] = 1'b0;
    endtask

    task automatic send(input wq_t w, input bit stall);
        sbq.push_back(model(w));
        n_cmp++; if (dataIn_ready !== 1'b1) begin n_err++; $display("FAIL send_ready: got %b want 1", dataIn_ready); end
        for (int i = 0; i < w.size(); i++) begin
            if (stall && i == 2) begin
                dataIn_val = 1'b0; dataIN_last = 1'b0;
                @(posedge clk); #1;
            end
            dataIn = w[i]; dataIn_val = 1'b1; dataIN_last = (i == w.size() - 1);
            @(posedge clk); #1;
        end
        dataIn_val = 1'b0; dataIN_last = 1'b0;
        n_cmp++; if (dataOut_val !== 1'b1) begin n_err++; $display("FAIL out_latency: got %b want 1", dataOut_val); end
    endtask

    task automatic recv(input int hold);
        exp_t         e;
        logic [0:295] d0;
        logic         l0;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_err++; $display("FAIL sb_empty: got 0 entries want >=1");
            e = '0;
        end else e = sbq.pop_front();
        d0 = dataOut; l0 = packetLost;
        n_cmp++; if (dataOut !== e.d) begin n_err++; $display("FAIL out_data: got %h want %h", dataOut, e.d); end
        n_cmp++; if (packetLost !== e.lost) begin n_err++; $display("FAIL out_lost: got %b want %b", packetLost, e.lost); end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_cmp++; if (dataOut_val !== 1'b1 || dataIn_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_flags: got val=%b rdy=%b want val=1 rdy=0", dataOut_val, dataIn_ready); end
            n_cmp++; if (dataOut !== d0 || packetLost !== l0) begin
                n_err++; $display("FAIL bp_stable: got %h/%b want %h/%b", dataOut, packetLost, d0, l0); end
        end
        dataOut_ready = 1'b1;
        @(posedge clk); #1;
        dataOut_ready = 1'b0;
        n_cmp++; if (dataOut_val !== 1'b0 || packetLost !== 1'b0) begin
            n_err++; $display("FAIL hs_drop: got val=%b lost=%b want 0/0", dataOut_val, packetLost); end
        n_cmp++; if (dataIn_ready !== 1'b1) begin n_err++; $display("FAIL hs_ready: got %b want 1", dataIn_ready); end
        n_cmp++; if (dataOut !== d0) begin n_err++; $display("FAIL hs_hold: got %h want %h", dataOut, d0); end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic();
        wq_t w;
        logic [95:0] exp_pay;
        exp_pay = 96'h012345620123456301234564;
        w = '{32'h14000C00, 32'h01000000, 32'h01234562, 32'h01234563, 32'h01234564};
        send(w, 1'b0);
        n_cmp++; if (dataOut[0:15] !== 16'd12) begin n_err++; $display("FAIL basic_sid: got %0d want 12", dataOut[0:15]); end
        n_cmp++; if (dataOut[16:47] !== 32'd1) begin n_err++; $display("FAIL basic_seq: got %0d want 1", dataOut[16:47]); end
        n_cmp++; if (dataOut[48:143] !== exp_pay) begin n_err++; $display("FAIL basic_pay: got %h want %h", dataOut[48:143], exp_pay); end
        n_cmp++; if (dataOut[144:295] !== 152'd0) begin n_err++; $display("FAIL basic_tail: got %h want 0", dataOut[144:295]); end
        n_cmp++; if (packetLost !== 1'b0) begin n_err++; $display("FAIL basic_lost: got %b want 0", packetLost); end
        recv(0);
    endtask

    task automatic test_new_stream();
        send(mk(25, 13, 32'd1, 7), 1'b0);
        n_cmp++; if (dataOut[184:295] !== 112'd0) begin n_err++; $display("FAIL newstr_mask: got %h want 0", dataOut[184:295]); end
        n_cmp++; if (packetLost !== 1'b0) begin n_err++; $display("FAIL newstr_lost: got %b want 0", packetLost); end
        recv(0);
    endtask

    task automatic test_gap();
        logic want;
`ifdef PARSER_SEQ_CHECK_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        send(mk(39, 12, 32'd3, 9), 1'b0);
        n_cmp++; if (packetLost !== want) begin n_err++; $display("FAIL gap_lost: got %b want %b", packetLost, want); end
        recv(0);
    endtask

    task automatic test_in_order();
        send(mk(16, 12, 32'd4, 2), 1'b0);          recv(0);
        send(mk(20, 5, 32'hFFFFFFFF, 3), 1'b1);    recv(0);
        send(mk(20, 5, 32'h00000000, 3), 1'b0);
        n_cmp++; if (packetLost !== 1'b0) begin n_err++; $display("FAIL wrap_lost: got %b want 0", packetLost); end
        recv(0);
        send(mk(20, 5, 32'h00000000, 3), 1'b0);    recv(0);  // duplicate
        send(mk(16, 28, 32'd1, 2), 1'b0);          recv(0);  // tag mismatch on entry 12
        send(mk(16, 12, 32'd5, 2), 1'b1);          recv(0);
    endtask

    task automatic test_short();
        wq_t w;
        wq_t w1;
        w = mk(30, 7, 32'd77, 4);
        w1 = '{w[0]};
        send(w1, 1'b0);
        n_cmp++; if (dataOut[16:295] !== 280'd0) begin n_err++; $display("FAIL short0_zero: got %h want 0", dataOut[16:295]); end
        recv(0);
        w1 = '{w[0], w[1]};
        send(w1, 1'b0);
        recv(0);
        send(mk(6, 7, 32'd79, 3), 1'b1);  recv(0);  // length below header size
    endtask

    task automatic test_backpressure();
        send(mk(20, 12, 32'd6, 3), 1'b0);
        recv(5);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            send(mk(8 + 4 * i + 3, 9, 32'(100 + i), i + 1), 1'b0);
            recv(0);
        end
    endtask

    task automatic test_reset_mid();
        wq_t w;
        exp_t junk;
        w = mk(40, 12, 32'd8, 4);
        for (int i = 0; i < 2; i++) begin
            dataIn = w[i]; dataIn_val = 1'b1; dataIN_last = 1'b0;
            @(posedge clk); #1;
        end
        do_reset();
        send(mk(20, 12, 32'd9, 3), 1'b0);
        n_cmp++; if (packetLost !== 1'b0) begin n_err++; $display("FAIL rstmid_lost: got %b want 0", packetLost); end
        recv(0);
        // reset while the output is pending drops it
        send(mk(16, 3, 32'd1, 2), 1'b0);
        junk = sbq.pop_back();
        do_reset();
        n_cmp++; if (dataOut_val !== 1'b0) begin n_err++; $display("FAIL rstout_val: got %b want 0", dataOut_val); end
        send(mk(16, 3, 32'd1, 2), 1'b0);
        recv(0);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin mv[i] = 1'b0; mtag[i] = '0; mseq[i] = '0; end
        test_reset();
        test_basic();
        test_new_stream();
        test_gap();
        test_in_order();
        test_short();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/parser.md
# parser

Streaming packet parser that sits between a 32-bit valid/ready byte-stream source and a packet consumer. It accepts a packet word by word, extracts the little-endian header (length, stream ID, sequence number) and up to 31 payload bytes, and presents the whole packet as one 296-bit word. Optionally, it tracks sequence numbers per stream and flags gaps on `packetLost`.

## Interface
- `NUM_STREAMS`, default 16: entries in the sequence-tracking table; must be a power of 2.
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset_b`  in  1: reset, synchronous, active-high (asserted = 1).
- `dataIn`  in  32: input beat. Byte 0 is in [31:24], byte 1 in [23:16], byte 2 in [15:8], byte 3 in [7:0].
- `dataIn_val`  in  1: input beat valid.
- `dataIn_ready`  out  1: parser can accept a beat.
- `dataIN_last`  in  1: the current beat is the final beat of the packet.
- `dataOut`  out  [0:295]: parsed packet.
- `dataOut_val`  out  1: `dataOut` and `packetLost` are valid.
- `dataOut_ready`  in  1: consumer accepts the output.
- `packetLost`  out  1: sequence gap detected for this packet's stream.

## Operation
- A beat transfers when `dataIn_val && dataIn_ready`. The packet byte index advances by 4 per beat.
- Header bytes (little-endian multi-byte fields):
  - Bytes 0–1: total length in bytes, header included.
  - Bytes 2–3: stream ID.
  - Bytes 4–7: sequence number.
  - Bytes 8 and up: payload.
- `dataOut` layout:
  - [0:15] stream ID, stored numerically with bit 0 as its MSB.
  - [16:47] sequence number.
  - [48:295] payload bytes 0..30; payload byte k occupies [48+8k : 55+8k].
- Payload bytes at or beyond `length-8` are zeroed, as are bytes never received. Payload bytes beyond 31 are accepted and discarded.
- The packet ends on the beat with `dataIN_last`; the length field never terminates a packet.
- Short packets:
  - `last` on beat 0: seq = 0 and payload = 0.
  - `last` on beat 1: payload = 0.
- FSM states:
  - HDR0 → HDR1 on beat 0.
  - HDR1 → PAYLOAD on beat 1.
  - PAYLOAD stays in PAYLOAD on each further beat.
  - Any state → OUT on a beat with `last`.
  - OUT → HDR0 when `dataOut_ready`.
- Sequence check (`PARSER_SEQ_CHECK_EN`):
  - Table entry index = stream ID[log2(NUM_STREAMS)-1:0]. Each entry holds {valid, tag = full stream ID, last_seq}.
  - On entering OUT: `packetLost` = entry valid && tag matches && seq != last_seq+1 (mod 2^32). The entry is then written {1, stream ID, seq}.
  - An invalid entry or a tag mismatch means a new stream: `packetLost` = 0 and the entry is overwritten.
  - Duplicate or older sequence numbers count as lost.

## Timing
- During reset:
  - `dataIn_ready`, `dataOut_val` and `packetLost` are 0.
  - `dataOut` is all zeros.
  - All table valid bits are cleared.
  - FSM goes to HDR0.
- `dataIn_ready` = 1 in HDR0, HDR1 and PAYLOAD, and 0 in OUT (one packet in flight, no overlap).
- `dataOut_val` rises on the cycle after the `last` beat is accepted.
- `dataOut` and `packetLost` are stable while `dataOut_val` = 1 and `dataOut_ready` = 0.
- The cycle with `dataOut_val && dataOut_ready` returns to HDR0. `dataIn_ready` = 1 on the next cycle, so the minimum gap is 1 idle input cycle per packet.
- After a handshake, `dataOut_val` and `packetLost` drop to 0. `dataOut` holds its last value.
- Reset mid-packet discards the partial packet.
- Reset while in OUT drops the pending output.
- `dataIn_val` low mid-packet stalls the FSM with no timeout.

## Configuration
- `PARSER_SEQ_CHECK_EN` defined: the sequence table and `packetLost` logic are built as described.
- `PARSER_SEQ_CHECK_EN` undefined: no table exists, `packetLost` is tied to 0, and parsing and output are unchanged.

## Test plan
- Basic packet: stream 12, seq 1, length 20, 5 beats (beat 0 = 0x14000C00, beat 1 = 0x01000000, beats 2–4 = 0x01234562..0x01234564).
  - Required: `dataOut_val` 1 cycle after the last beat.
  - [0:15]=12, [16:47]=1, payload bytes 0–11 = 01 23 45 62 01 23 45 63 01 23 45 64, rest 0.
  - `packetLost`=0.
- New stream: stream 13, seq 1, length 25 → `packetLost`=0; payload bytes 17..30 = 0.
- Gap: stream 12, seq 3, length 39 → `packetLost`=1 with `dataOut_val`; 31 payload bytes present.
- In-order sequence: stream 12 seq 4 after seq 3 → `packetLost`=0. Seq 0xFFFFFFFF followed by seq 0 → `packetLost`=0.
- Backpressure: hold `dataOut_ready`=0 for 5 cycles.
  - `dataIn_ready`=0 throughout and outputs stable.
  - Release → `dataIn_ready`=1 on the next cycle.
- Reset mid-packet after 2 beats, then send stream 12 seq 9 → partial packet is discarded, `packetLost`=0 (table cleared).
